// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the 640x480 @ 60 Hz VGA generator, plus the
// counter type and a small window-decode helper used by the sync decode.
// Default constants:
//   horizontal: 640 visible, 16 front, 96 sync, 48 back  -> 800 total
//   vertical  : 480 visible, 10 front,  2 sync, 33 back  -> 525 total
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Horizontal defaults (pixels)
    localparam int unsigned H_VISIBLE_DEF    = 640;
    localparam int unsigned H_FRONT_DEF      = 16;
    localparam int unsigned H_SYNC_DEF       = 96;
    localparam int unsigned H_BACK_DEF       = 48;
    localparam int unsigned H_TOTAL_DEF      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

    // Vertical defaults (lines)
    localparam int unsigned V_VISIBLE_DEF    = 480;
    localparam int unsigned V_FRONT_DEF      = 10;
    localparam int unsigned V_SYNC_DEF       = 2;
    localparam int unsigned V_BACK_DEF       = 33;
    localparam int unsigned V_TOTAL_DEF      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Half-open window test: lo <= value < hi
    function automatic logic in_span(input cnt_t value, input cnt_t lo, input cnt_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// Bundle between the pixel source, the timing generator and the connector.
//   red_in/green_in/blue_in : colour requested for the current coordinate
//   red_out/green_out/blue_out : gated colour to the DAC pins (0 when blanked)
//   hsync/vsync             : active-low sync pulses
//   hor_count/ver_count     : current pixel column / line
// master = pixel source side, slave = timing generator (vga_logic).
// -----------------------------------------------------------------------------
interface vga_if import vga_pkg::*; ();

    logic red_in;
    logic green_in;
    logic blue_in;
    logic red_out;
    logic green_out;
    logic blue_out;
    logic hsync;
    logic vsync;
    cnt_t hor_count;
    cnt_t ver_count;

    modport master (
        output red_in, green_in, blue_in,
        input  red_out, green_out, blue_out, hsync, vsync, hor_count, ver_count
    );

    modport slave (
        input  red_in, green_in, blue_in,
        output red_out, green_out, blue_out, hsync, vsync, hor_count, ver_count
    );

endinterface

// File: rtl/vga_sync_counter.sv
// -----------------------------------------------------------------------------
// vga_sync_counter
// Divides clk by two into a pixel enable and runs the horizontal/vertical
// position counters with wrap-around.
//   clk, rst        : system clock, asynchronous active-high reset
//   pix_en_o        : high on the clk cycle whose edge advances the counters
//   hor_count_o     : registered pixel column
//   ver_count_o     : registered line
//   hor_next_o      : value hor_count_o takes on the coming edge
//   ver_next_o      : value ver_count_o takes on the coming edge
// -----------------------------------------------------------------------------
module vga_sync_counter import vga_pkg::*; #(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o,
    output cnt_t hor_count_o,
    output cnt_t ver_count_o,
    output cnt_t hor_next_o,
    output cnt_t ver_next_o
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    logic phase_q;
    logic phase_d;
    cnt_t hor_q;
    cnt_t hor_d;
    cnt_t ver_q;
    cnt_t ver_d;

    // Next-state for the phase divider and the position counters
    always_comb begin
        phase_d = ~phase_q;
        hor_d   = hor_q;
        ver_d   = ver_q;
        // The counters only move on the edge that ends a phase=1 cycle
        if (phase_q) begin
            if (hor_q == H_LAST) begin
                hor_d = CNT_ZERO;
                if (ver_q == V_LAST) begin
                    ver_d = CNT_ZERO;
                end else begin
                    ver_d = ver_q + CNT_ONE;
                end
            end else begin
                hor_d = hor_q + CNT_ONE;
                ver_d = ver_q;
            end
        end else begin
            hor_d = hor_q;
            ver_d = ver_q;
        end
    end

    // State registers for phase and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hor_q   <= CNT_ZERO;
            ver_q   <= CNT_ZERO;
        end else begin
            phase_q <= phase_d;
            hor_q   <= hor_d;
            ver_q   <= ver_d;
        end
    end

    assign pix_en_o    = phase_q;
    assign hor_count_o = hor_q;
    assign ver_count_o = ver_q;
    assign hor_next_o  = hor_d;
    assign ver_next_o  = ver_d;

endmodule

// File: rtl/vga_logic.sv
// -----------------------------------------------------------------------------
// vga_logic
// VGA timing generator and colour gate, run from the 50 MHz system clock.
//   clk, rst : system clock, asynchronous active-high reset
//   vga      : vga_if slave port (colour in, gated colour out, hsync/vsync,
//              hor_count/ver_count)
// Sync and colour registers are loaded from a decode of the counters' *next*
// values on each pixel-enable edge, so they change in the same edge as the
// counters and always describe the coordinate currently shown on
// hor_count/ver_count.
// -----------------------------------------------------------------------------
module vga_logic import vga_pkg::*; #(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic  clk,
    input  logic  rst,
    vga_if.slave  vga
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam cnt_t H_VIS_LIM    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS_LIM    = cnt_t'(V_VISIBLE);
    localparam cnt_t H_SYNC_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t V_SYNC_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       pix_en_s;
    cnt_t       hor_count_s;
    cnt_t       ver_count_s;
    cnt_t       hor_next_s;
    cnt_t       ver_next_s;
    logic       visible_s;

    logic       hsync_q;
    logic       hsync_d;
    logic       vsync_q;
    logic       vsync_d;
    logic [2:0] rgb_q;
    logic [2:0] rgb_d;

    vga_sync_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .pix_en_o    (pix_en_s),
        .hor_count_o (hor_count_s),
        .ver_count_o (ver_count_s),
        .hor_next_o  (hor_next_s),
        .ver_next_o  (ver_next_s)
    );

    // Visible-area, sync and colour decode of the upcoming coordinate
    always_comb begin
        visible_s = (hor_next_s < H_VIS_LIM) && (ver_next_s < V_VIS_LIM);
        hsync_d   = ~in_span(hor_next_s, H_SYNC_START, H_SYNC_END);
        vsync_d   = ~in_span(ver_next_s, V_SYNC_START, V_SYNC_END);
        rgb_d     = {vga.red_in, vga.green_in, vga.blue_in} & {3{visible_s}};
    end

    // Output registers, loaded only on pixel-enable edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
        end else if (pix_en_s) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end else begin
            hsync_q <= hsync_q;
            vsync_q <= vsync_q;
            rgb_q   <= rgb_q;
        end
    end

    assign vga.red_out   = rgb_q[2];
    assign vga.green_out = rgb_q[1];
    assign vga.blue_out  = rgb_q[0];
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.hor_count = hor_count_s;
    assign vga.ver_count = ver_count_s;

endmodule

// File: tb/tb_vga_logic.sv
// -----------------------------------------------------------------------------
// tb_vga_logic
// Drives two instances: one with the default 640x480 timing and one with a
// shrunken timing so whole frames fit in a short run. Both are compared every
// clock against a reference that derives position from the number of clk
// edges since reset release.
// -----------------------------------------------------------------------------
module tb_vga_logic;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } tim_t;

    typedef struct {
        logic [2:0] rgb_in;
        logic [2:0] rgb_exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int         checks = 0;
    int         errors = 0;
    int         n = 0;          // clk edges since reset release
    logic [2:0] smp = 3'b000;   // colour sampled on the latest pixel enable
    logic [2:0] cur_in = 3'b000;
    tim_t       tim_def;
    tim_t       tim_sml;

    always #10 clk = ~clk;

    vga_if bus_d ();
    vga_if bus_s ();

    vga_logic dut_def (
        .clk (clk),
        .rst (rst),
        .vga (bus_d)
    );

    vga_logic #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
        .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_sml (
        .clk (clk),
        .rst (rst),
        .vga (bus_s)
    );

    // Reference: position is (edges/2) pixels into the raster, mod frame size
    function automatic void model(input tim_t t, input int nn, input logic [2:0] s,
                                  output int hor, output int ver, output int hs,
                                  output int vs, output int rgb);
        int ht, vt, p, k;
        ht  = t.hv + t.hf + t.hs + t.hb;
        vt  = t.vv + t.vf + t.vs + t.vb;
        p   = nn / 2;
        k   = p % (ht * vt);
        hor = k % ht;
        ver = k / ht;
        hs  = (hor >= t.hv + t.hf && hor < t.hv + t.hf + t.hs) ? 0 : 1;
        vs  = (ver >= t.vv + t.vf && ver < t.vv + t.vf + t.vs) ? 0 : 1;
        rgb = (p >= 1 && hor < t.hv && ver < t.vv) ? int'(s) : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_dut(input string tag, input tim_t t, input int h, input int v,
                             input int hs, input int vs, input int r, input int g, input int b);
        int eh, ev, ehs, evs, ergb;
        model(t, n, smp, eh, ev, ehs, evs, ergb);
        chk({tag, ".hor_count"}, h, eh);
        chk({tag, ".ver_count"}, v, ev);
        chk({tag, ".hsync"}, hs, ehs);
        chk({tag, ".vsync"}, vs, evs);
        chk({tag, ".red_out"}, r, (ergb >> 2) & 1);
        chk({tag, ".green_out"}, g, (ergb >> 1) & 1);
        chk({tag, ".blue_out"}, b, ergb & 1);
    endtask

    task automatic check_both();
        check_dut("def", tim_def, int'(bus_d.hor_count), int'(bus_d.ver_count),
                  int'(bus_d.hsync), int'(bus_d.vsync),
                  int'(bus_d.red_out), int'(bus_d.green_out), int'(bus_d.blue_out));
        check_dut("sml", tim_sml, int'(bus_s.hor_count), int'(bus_s.ver_count),
                  int'(bus_s.hsync), int'(bus_s.vsync),
                  int'(bus_s.red_out), int'(bus_s.green_out), int'(bus_s.blue_out));
    endtask

    task automatic set_rgb(input logic [2:0] c);
        cur_in         = c;
        bus_d.red_in   = c[2];
        bus_d.green_in = c[1];
        bus_d.blue_in  = c[0];
        bus_s.red_in   = c[2];
        bus_s.green_in = c[1];
        bus_s.blue_in  = c[0];
    endtask

    // One clk period: advance the reference on the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            n++;
            if (n % 2 == 0) smp = cur_in;
        end
        @(negedge clk);
        check_both();
    endtask

    initial begin
        vec_t       tbl [8];
        logic [2:0] prev_exp;
        int         hs_fall_n, hs_rise_n, vs_fall0, vs_fall1;
        logic       prev_hs, prev_vs;

        tim_def = '{640, 16, 96, 48, 480, 10, 2, 33};
        tim_sml = '{16, 4, 6, 6, 10, 2, 2, 3};

        tbl[0] = '{3'b101, 3'b101};
        tbl[1] = '{3'b010, 3'b010};
        tbl[2] = '{3'b111, 3'b111};
        tbl[3] = '{3'b000, 3'b000};
        tbl[4] = '{3'b100, 3'b100};
        tbl[5] = '{3'b001, 3'b001};
        tbl[6] = '{3'b011, 3'b011};
        tbl[7] = '{3'b110, 3'b110};

        set_rgb(3'b111);

        // Reset held for 5 clk: outputs stay at reset values despite inputs=1
        @(negedge clk);
        for (int i = 0; i < 5; i++) tick();
        chk("reset.hsync", int'(bus_d.hsync), 1);
        chk("reset.red_out", int'(bus_d.red_out), 0);

        // Release between edges, then colour-gating table in the visible area
        rst      = 1'b0;
        prev_exp = 3'b000;
        for (int i = 0; i < 8; i++) begin
            set_rgb(tbl[i].rgb_in);
            tick();
            chk("tbl.hold", int'({bus_d.red_out, bus_d.green_out, bus_d.blue_out}), int'(prev_exp));
            if (i == 0) chk("first.hor_after_1_edge", int'(bus_d.hor_count), 0);
            tick();
            chk("tbl.gate", int'({bus_d.red_out, bus_d.green_out, bus_d.blue_out}), int'(tbl[i].rgb_exp));
            if (i == 0) chk("first.hor_after_2_edges", int'(bus_d.hor_count), 1);
            prev_exp = tbl[i].rgb_exp;
        end

        // Random colour run over two default lines and several small frames
        hs_fall_n = -1; hs_rise_n = -1; vs_fall0 = -1; vs_fall1 = -1;
        prev_hs   = bus_d.hsync;
        prev_vs   = bus_s.vsync;
        while (n < 3800) begin
            if ((n >= 1270 && n <= 1290) || n >= 3780) set_rgb(3'b111);
            else set_rgb(3'($urandom_range(0, 7)));
            tick();
            if (n == 1278) chk("blank.edge_639", int'(bus_d.red_out), 1);
            if (n == 1280) chk("blank.edge_640", int'(bus_d.red_out), 0);
            if (prev_hs && !bus_d.hsync && hs_fall_n < 0) hs_fall_n = n;
            if (!prev_hs && bus_d.hsync && hs_rise_n < 0) hs_rise_n = n;
            if (prev_vs && !bus_s.vsync) begin
                if (vs_fall0 < 0) vs_fall0 = n;
                else if (vs_fall1 < 0) vs_fall1 = n;
            end
            prev_hs = bus_d.hsync;
            prev_vs = bus_s.vsync;
        end
        chk("hsync.fall_edge", hs_fall_n, 1312);
        chk("hsync.rise_edge", hs_rise_n, 1504);
        chk("sml.vsync.first_fall", vs_fall0, 768);
        chk("sml.frame_period", vs_fall1 - vs_fall0, 1088);
        chk("pre_reset.hor_count", int'(bus_d.hor_count), 300);
        chk("pre_reset.red_out", int'(bus_d.red_out), 1);

        // Mid-frame asynchronous reset, asserted away from any clock edge
        #3;
        rst = 1'b1;
        n   = 0;
        smp = 3'b000;
        #1;
        check_both();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            set_rgb(3'($urandom_range(0, 7)));
            tick();
        end
        chk("restart.hor_count", int'(bus_d.hor_count), 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_logic.md
# vga_logic

VGA 640x480 @ 60 Hz timing generator and colour gate, run from the 50 MHz system clock. It produces active-low hsync/vsync, exposes the current pixel coordinates to upstream pixel logic, and passes the 1-bit R/G/B inputs to the DAC pins only inside the visible area. It sits between the pixel-source logic and the board VGA connector.

## Interface
- Parameters (defaults = 640x480@60):
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch (V_TOTAL = 525)
- Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; asynchronous, active-high
- red_in / green_in / blue_in  in  1 each  pixel colour requested for the current coordinate
- red_out / green_out / blue_out  out  1 each  colour to the connector; 0 when blanked
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- hor_count  out  10  current pixel column, 0..799
- ver_count  out  10  current line, 0..524

## Operation
- An internal 1-bit phase toggles on every clk edge. The pixel enable (25 MHz) is asserted when the phase is 1.
- On each pixel enable, hor_count increments. When hor_count is 799, it wraps to 0 and ver_count increments. When ver_count is 524 and hor_count wraps, ver_count wraps to 0.
- hsync is low for hor_count 656..751 and high otherwise. vsync is low for ver_count 490..491 and high otherwise.
- Visible area is hor_count < 640 and ver_count < 480.
- colour_out = colour_in AND visible, for each of R/G/B independently.
- All outputs are registered and update only on pixel-enable edges. sync and colour are decoded from the next counter values, so all outputs change together and stay mutually consistent.
- Counter arithmetic is unsigned 10-bit. Values above the totals are unreachable.

## Timing
- Reset state (rst=1, asynchronous): phase=0, hor_count=0, ver_count=0, hsync=1, vsync=1, R/G/B out=0.
- After rst falls:
  - The first clk edge sets phase=1.
  - The second edge is the first pixel enable: counters go to (1,0) and colour reflects the inputs for (1,0).
  - Pixel (0,0) is therefore black in the first frame only.
- Every coordinate is held for exactly 2 clk cycles (40 ns).
- Line period is 1600 clk (32 µs). Frame period is 840 000 clk (16.8 ms).
- hsync low time is 192 clk. vsync low time is 2 lines (3200 clk).
- Colour inputs are sampled on the pixel-enable edge. Latency from colour_in to colour_out is one pixel enable; no pipelining beyond that.
- Reset asserted mid-frame forces the reset state immediately, without waiting for a clock edge. Counting restarts from (0,0) as above.

## Structure
- Shared package vga_pkg holds the timing constants: H/V visible, porch, sync and total values, plus derived sync start/end.
- Natural sub-module vga_sync_counter contains the phase divider plus the hor/ver counters with wrap logic. It outputs counters and the pixel enable.
- The top level (vga_logic) holds the visible/sync decode and the output registers.

## Test plan
- Reset: hold rst=1 for 5 clk -> counters 0, hsync=1, vsync=1, RGB=0. Release -> hor_count=1 at the 2nd edge, then +1 every 2 clk.
- Horizontal sync: from line start -> hsync falls when hor_count becomes 656 (1312 clk after hor_count=0) and rises at 752. Line repeats every 1600 clk; hor_count wraps 799->0 with ver_count+1.
- Vertical sync: vsync falls when ver_count becomes 490 at hor_count=0 and rises at ver_count=492. ver_count wraps 524->0; frame = 840 000 clk.
- Blanking, with RGB inputs all 1:
  - out=1 at (639,0) and 0 at (640,0).
  - out=0 for all of ver_count 480..524.
  - out=1 again at (0,0) of the next frame.
- Colour gating: red_in=1, green_in=0, blue_in=1 in visible area -> red_out=1, green_out=0, blue_out=1. Toggling inputs mid-line is reflected one pixel enable later.
- Mid-frame reset: assert rst at (300,200) between clk edges -> outputs go to reset values immediately, with no clock edge. After release, timing restarts from (0,0).
